comp_sched: RTL and testbench
=============================

# comp_sched

Round-robin scheduler that shares one bit-serial magnitude comparator among four requesters. Each requester presents a WIDTH-bit operand pair with a level request. The block grants one requester, sequences the 1-bit gt/eq/lt compare slice from MSB to LSB with early exit on the first differing bit, and returns registered gt/eq/lt flags with a one-cycle done pulse. It sits between requesting datapath blocks and the compare slice.

## Interface
- WIDTH, 8, operand width in bits (≥2); requester count fixed at 4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  level request per requester; bit i = requester i
- a_in  input  4*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- b_in  input  4*WIDTH  operand B; same packing
- gnt  output  4  one-hot grant, held from grant edge through DONE cycle
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse, result valid
- done_id  output  2  index of requester served; valid with done, held after
- gt  output  1  A > B (unsigned)
- eq  output  1  A == B
- lt  output  1  A < B

## Operation
- States: IDLE, CMP, DONE.
- IDLE: if req != 0, select a winner by round-robin, searching from index ptr upward with wrap (ptr, ptr+1, … mod 4). On the clock edge:
  - gnt <= onehot(winner)
  - a_sh/b_sh <= operands of winner
  - cnt <= WIDTH-1
  - state <= CMP
- CMP: each cycle, compare a_sh[WIDTH-1] with b_sh[WIDTH-1].
  - Bits differ: gt <= a bit, lt <= b bit, eq <= 0; state <= DONE.
  - Bits equal and cnt == 0: eq <= 1, gt <= 0, lt <= 0; state <= DONE.
  - Bits equal and cnt != 0: shift a_sh/b_sh left by 1; cnt <= cnt-1.
- DONE: done = 1 and done_id = winner for exactly one cycle. On the edge: ptr <= winner+1 mod 4, gnt <= 0, state <= IDLE.
- gt/eq/lt/done_id hold their last result until the next DONE. Exactly one of gt/eq/lt is high after the first completion.
- Comparison is unsigned. Operands are sampled only at the grant edge; later changes on a_in/b_in are ignored.
- req is sampled only in IDLE. Dropping req during CMP does not abort; the operation completes and done still pulses.
- A requester holding req through done re-competes in IDLE, with other requesters ahead of it via ptr.
- No arbitration occurs in DONE. The earliest next grant edge is the IDLE cycle after DONE.

## Timing
- Reset (async, immediate on rst_n low): state IDLE, gnt=0, busy=0, done=0, done_id=0, gt=eq=lt=0, ptr=0 (requester 0 highest priority), cnt=0, shift regs 0.
- Reset mid-operation: the operation is discarded, no done pulse, and all outputs take their reset values.
- Let cycle t be the IDLE cycle with req sampled non-zero.
  - gnt/busy high from t+1.
  - First differing bit at MSB-relative position k (0 = MSB): done in cycle t+2+k.
  - Equal operands: done in cycle t+1+WIDTH.
- Throughput: minimum 3 cycles per operation (IDLE, CMP, DONE).
- Outputs are all registered or decoded from state; there is no combinational path from req/a_in/b_in to any output.

## Test plan
- Reset: drive rst_n=0 mid-clock → all outputs 0 immediately. Release with req=0 → outputs stay 0, busy=0.
- WIDTH=8, req=0001, a=0x80, b=0x7F at cycle t → gnt=0001 at t+1; done, gt=1, eq=lt=0, done_id=0 at t+2; gnt=0 at t+3.
- req=0100, a=0x35, b=0x35 → eq=1, gt=lt=0, done_id=2 at t+9. a=0x12, b=0x13 → lt=1 at t+9 (k=7).
- req=1111 held with distinct operands → grants in order 0001, 0010, 0100, 1000, 0001, each 3+ cycles apart. Each done_id matches its grant and results match the respective operands.
- req=0010 with a=0xF0, b=0x0F. Drop req and change a_in/b_in at t+1 → operation completes with gt=1 at t+2 and the original operands are used.
- Assert rst_n=0 during CMP of a grant to requester 3 → no done pulse, gnt=0, ptr=0. Then req=1001 → requester 0 is granted first.

Source files
------------

// File: rtl/comp_sched.sv
// -----------------------------------------------------------------------------
// comp_sched
//   Round-robin scheduler sharing one bit-serial magnitude comparator among
//   four requesters. A winner is picked in IDLE, its operand pair is captured,
//   and the compare slice walks MSB->LSB with early exit on the first
//   differing bit. Results are registered and announced by a one-cycle done.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      level request, bit i = requester i
//   a_in     operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in     operand B, same packing
//   gnt      one-hot grant, held from grant edge through the DONE cycle
//   busy     high whenever the scheduler is not idle
//   done     one-cycle pulse, result valid
//   done_id  requester index served (held until the next completion)
//   gt/eq/lt unsigned compare result (held until the next completion)
// -----------------------------------------------------------------------------
module comp_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_id,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [1:0]       ptr_q,     ptr_d;
  logic [1:0]       win_q,     win_d;
  logic [3:0]       gnt_q,     gnt_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [1:0]       done_id_q, done_id_d;
  logic             gt_q,      gt_d;
  logic             eq_q,      eq_d;
  logic             lt_q,      lt_d;

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod 4.
  logic       any_req;
  logic [1:0] win_sel;
  logic [1:0] scan_idx;

  always_comb begin
    any_req  = 1'b0;
    win_sel  = ptr_q;
    scan_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!any_req && req[scan_idx]) begin
        any_req = 1'b1;
        win_sel = scan_idx;
      end
    end
  end

  // Only the MSBs of the shift registers are looked at each CMP cycle.
  logic a_bit;
  logic b_bit;
  assign a_bit = a_sh_q[WIDTH-1];
  assign b_bit = b_sh_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = win_sel;
          gnt_d   = 4'b0001 << win_sel;
          a_sh_d  = a_in[win_sel*WIDTH +: WIDTH];
          b_sh_d  = b_in[win_sel*WIDTH +: WIDTH];
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        if (a_bit != b_bit) begin
          gt_d      = a_bit;
          lt_d      = b_bit;
          eq_d      = 1'b0;
          done_id_d = win_q;
          state_d   = S_DONE;
        end else if (cnt_q == '0) begin
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          eq_d      = 1'b1;
          done_id_d = win_q;
          state_d   = S_DONE;
        end else begin
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        // Served requester drops to lowest priority for the next pick.
        ptr_d   = win_q + 2'd1;
        gnt_d   = 4'b0000;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      done_id_q <= 2'd0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign gt      = gt_q;
  assign eq      = eq_q;
  assign lt      = lt_q;

endmodule

// File: tb/tb_comp_sched.sv
// -----------------------------------------------------------------------------
// tb_comp_sched
//   Directed bench for comp_sched (WIDTH=8). Each task drives one scenario
//   and checks outputs 1 time unit after the rising edge against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_comp_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        gt;
  logic        eq;
  logic        lt;

  int n_tests;
  int n_fail;
  int cyc;

  comp_sched #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .gt      (gt),
    .eq      (eq),
    .lt      (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
    a_in[idx*8 +: 8] = a;
    b_in[idx*8 +: 8] = b;
  endtask

  task automatic check_zero_outputs(input string tag);
    n_tests++;
    if ({gnt, busy, done, done_id, gt, eq, lt} !== 11'd0) begin
      n_fail++;
      $display("FAIL %s: gnt=%b busy=%b done=%b done_id=%0d gt=%b eq=%b lt=%b, want all 0",
               tag, gnt, busy, done, done_id, gt, eq, lt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    a_in  = '0;
    b_in  = '0;
    #2;
    check_zero_outputs("reset_assert");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_zero_outputs("reset_release_idle");
    $display("[TB] test_reset done at cycle %0d", cyc);
  endtask

  // a=0x80 vs b=0x7F: MSB differs, done at t+2.
  task automatic test_gt_msb();
    set_op(0, 8'h80, 8'h7F);
    req = 4'b0001;                       // cycle t
    tick();                              // t+1
    n_tests++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL gt_msb_grant: gnt=%b busy=%b done=%b, want 0001 1 0", gnt, busy, done);
    end
    req = 4'b0000;
    tick();                              // t+2
    n_tests++;
    if (done !== 1'b1 || gt !== 1'b1 || eq !== 1'b0 || lt !== 1'b0 || done_id !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL gt_msb_done: done=%b gt=%b eq=%b lt=%b id=%0d gnt=%b, want 1 1 0 0 0 0001",
               done, gt, eq, lt, done_id, gnt);
    end
    tick();                              // t+3
    n_tests++;
    if (gnt !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || gt !== 1'b1) begin
      n_fail++;
      $display("FAIL gt_msb_after: gnt=%b done=%b busy=%b gt=%b, want 0000 0 0 1 (held)", gnt, done, busy, gt);
    end
    $display("[TB] test_gt_msb done at cycle %0d", cyc);
  endtask

  // Full-length compares on requester 2: equal, then differing only at LSB.
  task automatic test_eq_lt();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_op(2, 8'h35, 8'h35);
      else           set_op(2, 8'h12, 8'h13);
      req = 4'b0100;                     // cycle t
      tick();                            // t+1
      n_tests++;
      if (gnt !== 4'b0100) begin
        n_fail++;
        $display("FAIL eq_lt_grant[%0d]: gnt=%b want 0100", pass, gnt);
      end
      req = 4'b0000;
      for (int k = 2; k <= 8; k++) tick();   // t+8
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL eq_lt_early[%0d]: done=%b busy=%b at t+8, want 0 1", pass, done, busy);
      end
      tick();                            // t+9
      n_tests++;
      if (pass == 0) begin
        if (done !== 1'b1 || eq !== 1'b1 || gt !== 1'b0 || lt !== 1'b0 || done_id !== 2'd2) begin
          n_fail++;
          $display("FAIL eq_done: done=%b gt=%b eq=%b lt=%b id=%0d, want 1 0 1 0 2", done, gt, eq, lt, done_id);
        end
      end else begin
        if (done !== 1'b1 || lt !== 1'b1 || gt !== 1'b0 || eq !== 1'b0 || done_id !== 2'd2) begin
          n_fail++;
          $display("FAIL lt_done: done=%b gt=%b eq=%b lt=%b id=%0d, want 1 0 0 1 2", done, gt, eq, lt, done_id);
        end
      end
      tick();                            // t+10, idle
    end
    $display("[TB] test_eq_lt done at cycle %0d", cyc);
  endtask

  // All four requesting continuously; grants must rotate 0,1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [2:0] exp_res [4];             // {gt,eq,lt}
    int         last_grant;
    int         n;
    rst_n = 1'b0;                        // restart with ptr=0
    #1;
    rst_n = 1'b1;
    set_op(0, 8'h80, 8'h10); exp_res[0] = 3'b100;
    set_op(1, 8'h01, 8'h81); exp_res[1] = 3'b001;
    set_op(2, 8'h55, 8'h55); exp_res[2] = 3'b010;
    set_op(3, 8'hC0, 8'h40); exp_res[3] = 3'b100;
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    last_grant = -100;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      n_tests++;
      if (gnt !== exp_gnt[g] || (cyc - last_grant) < 3) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b want %b, spacing=%0d cycles (min 3)",
                 g, gnt, exp_gnt[g], cyc - last_grant);
      end
      last_grant = cyc;
      if (g == 4) req = 4'b0000;
      n = 0;
      while (done !== 1'b1 && n < 20) begin tick(); n++; end
      n_tests++;
      if (done !== 1'b1 || done_id !== 2'(g % 4) || {gt, eq, lt} !== exp_res[g % 4]) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: done=%b id=%0d gt/eq/lt=%b, want 1 %0d %b",
                 g, done, done_id, {gt, eq, lt}, g % 4, exp_res[g % 4]);
      end
      tick();                            // IDLE cycle after DONE
    end
    n_tests++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_idle: busy=%b gnt=%b, want 0 0000", busy, gnt);
    end
    $display("[TB] test_round_robin done at cycle %0d", cyc);
  endtask

  // Operands and req change after the grant edge; captured values must win.
  task automatic test_operand_capture();
    set_op(1, 8'hF0, 8'h0F);
    req = 4'b0010;                       // cycle t (ptr=1)
    tick();                              // t+1
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL cap_grant: gnt=%b want 0010", gnt);
    end
    req = 4'b0000;
    set_op(1, 8'h00, 8'hFF);
    tick();                              // t+2
    n_tests++;
    if (done !== 1'b1 || gt !== 1'b1 || lt !== 1'b0 || eq !== 1'b0 || done_id !== 2'd1) begin
      n_fail++;
      $display("FAIL cap_done: done=%b gt=%b eq=%b lt=%b id=%0d, want 1 1 0 0 1", done, gt, eq, lt, done_id);
    end
    tick();                              // t+3, idle, ptr=2
    $display("[TB] test_operand_capture done at cycle %0d", cyc);
  endtask

  // Reset during a long compare on requester 3, then check ptr restarted at 0.
  task automatic test_reset_mid_op();
    set_op(3, 8'h01, 8'h01);
    req = 4'b1000;
    tick();                              // t+1
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_mid_grant: gnt=%b want 1000", gnt);
    end
    req = 4'b0000;
    tick();                              // t+2, CMP
    #2;
    rst_n = 1'b0;                        // mid-cycle
    #1;
    check_zero_outputs("rst_mid_immediate");
    tick();
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: done=%b want 0", done);
    end
    rst_n = 1'b1;
    set_op(0, 8'h10, 8'h90);
    set_op(3, 8'hFF, 8'h00);
    req = 4'b1001;                       // cycle t
    tick();                              // t+1
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_ptr: gnt=%b want 0001", gnt);
    end
    req = 4'b0000;
    tick();                              // t+2
    n_tests++;
    if (done !== 1'b1 || lt !== 1'b1 || done_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after: done=%b lt=%b id=%0d, want 1 1 0", done, lt, done_id);
    end
    tick();
    $display("[TB] test_reset_mid_op done at cycle %0d", cyc);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    test_reset();
    test_gt_msb();
    test_eq_lt();
    test_round_robin();
    test_operand_capture();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
